program_counter_unit: RTL and testbench

Instruction-sequencing stage directly downstream of the control unit. It consumes the decoded `jump`, `bzero`, `bnegative`, `mainAddress`, `HLT` and flag-enable controls, latches the ALU zero/negative flags, and produces the next instruction address for instruction memory. It also holds the processor in a halt state or an input-wait state.

---
 rtl/program_counter_unit_pkg.sv | 14 +
 rtl/program_counter_unit_syncEdgeDetect.sv | 29 ++
 rtl/program_counter_unit.sv | 147 ++++++++++++++
 tb/tb_program_counter_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/program_counter_unit_pkg.sv
// Shared types and defaults for the program counter unit.
// State encoding and address parameters.
package program_counter_unit_pkg;

  localparam int PCU_ADDR_WIDTH = 10;
  localparam int unsigned PCU_RESET_PC = 0;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    WAIT_IN = 2'b01,
    HALT    = 2'b10
  } pcu_state_e;

endpackage

// File: rtl/program_counter_unit_syncEdgeDetect.sv
// Two-flop synchronizer for an async button plus a
// registered single-cycle rising-edge pulse.
module syncEdgeDetect (
  input  logic clock,
  input  logic resetn,
  input  logic async_i,
  output logic rise_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       rise_q;

  // Metastability chain, history bit and pulse register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], async_i};
      prev_q <= sync_q[1];
      rise_q <= sync_q[1] & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/program_counter_unit.sv
// Next-PC sequencing with branch flags, halt and
// operator input-wait states.
module program_counter_unit
  import program_counter_unit_pkg::*;
#(
  parameter int          ADDR_WIDTH = PCU_ADDR_WIDTH,
  parameter int unsigned RESET_PC   = PCU_RESET_PC
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  jump,
  input  logic                  bzero,
  input  logic                  bnegative,
  input  logic [ADDR_WIDTH-1:0] mainAddress,
  input  logic                  HLT,
  input  logic                  enable,
  input  logic                  aluZero,
  input  logic                  aluNegative,
  input  logic                  inRequest,
  input  logic                  inConfirm,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted,
  output logic                  stall,
  output logic                  zeroFlag,
  output logic                  negFlag
);

  pcu_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  zf_q, zf_d;
  logic                  nf_q, nf_d;
  logic                  confirm_rise;
  logic                  take;
  logic [ADDR_WIDTH-1:0] pc_inc;

  syncEdgeDetect u_confirm (
    .clock   (clock),
    .resetn  (resetn),
    .async_i (inConfirm),
    .rise_o  (confirm_rise)
  );

  // Branch decision uses only the registered flags.
  assign take = jump
              | (bzero & zf_q)
              | (bnegative & nf_q);

  assign pc_inc = pc_q + ADDR_WIDTH'(1);

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; HALT is left only by reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (HLT) begin
          state_d = HALT;
        end else if (!take && inRequest) begin
          state_d = WAIT_IN;
        end
      end
      WAIT_IN: begin
        if (confirm_rise) begin
          state_d = RUN;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State-decoded status outputs.
  always_comb begin
    halted = 1'b0;
    stall  = 1'b0;
    unique case (state_q)
      WAIT_IN: stall  = 1'b1;
      HALT:    halted = 1'b1;
      default: begin
        halted = 1'b0;
        stall  = 1'b0;
      end
    endcase
  end

  // Next PC and flag values by state and priority.
  always_comb begin
    pc_d = pc_q;
    zf_d = zf_q;
    nf_d = nf_q;
    unique case (state_q)
      RUN: begin
        if (enable) begin
          zf_d = aluZero;
          nf_d = aluNegative;
        end
        if (HLT) begin
          pc_d = pc_q;
        end else if (take) begin
          pc_d = mainAddress;
        end else if (inRequest) begin
          pc_d = pc_q;
        end else begin
          pc_d = pc_inc;
        end
      end
      WAIT_IN: begin
        if (confirm_rise) begin
          pc_d = pc_inc;
        end
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  // PC and flag registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pc_q <= ADDR_WIDTH'(RESET_PC);
      zf_q <= 1'b0;
      nf_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      zf_q <= zf_d;
      nf_q <= nf_d;
    end
  end

  assign pc       = pc_q;
  assign zeroFlag = zf_q;
  assign negFlag  = nf_q;

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed bench for program_counter_unit with an
// expected-value queue checked after each clock edge.
module tb_program_counter_unit;

  logic       clock;
  logic       resetn;
  logic       jump;
  logic       bzero;
  logic       bnegative;
  logic [9:0] mainAddress;
  logic       HLT;
  logic       enable;
  logic       aluZero;
  logic       aluNegative;
  logic       inRequest;
  logic       inConfirm;
  logic [9:0] pc;
  logic       halted;
  logic       stall;
  logic       zeroFlag;
  logic       negFlag;

  typedef struct {
    string      tag;
    logic [9:0] pc;
    logic       h;
    logic       s;
    logic       z;
    logic       n;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  program_counter_unit dut (
    .clock       (clock),
    .resetn      (resetn),
    .jump        (jump),
    .bzero       (bzero),
    .bnegative   (bnegative),
    .mainAddress (mainAddress),
    .HLT         (HLT),
    .enable      (enable),
    .aluZero     (aluZero),
    .aluNegative (aluNegative),
    .inRequest   (inRequest),
    .inConfirm   (inConfirm),
    .pc          (pc),
    .halted      (halted),
    .stall       (stall),
    .zeroFlag    (zeroFlag),
    .negFlag     (negFlag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic push(input string tag, input int p,
                      input bit h, input bit s,
                      input bit z, input bit n);
    exp_t e;
    e.tag = tag;
    e.pc  = 10'(p);
    e.h   = h;
    e.s   = s;
    e.z   = z;
    e.n   = n;
    sb.push_back(e);
  endtask

  task automatic check_one();
    exp_t e;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL %s observed=empty expected=entry", "queue");
      return;
    end
    e = sb.pop_front();
    total++;
    assert (pc === e.pc) else begin
      bad++;
      $error("FAIL %s.pc observed=%0d expected=%0d",
             e.tag, pc, e.pc);
    end
    total++;
    assert (halted === e.h) else begin
      bad++;
      $error("FAIL %s.halted observed=%b expected=%b",
             e.tag, halted, e.h);
    end
    total++;
    assert (stall === e.s) else begin
      bad++;
      $error("FAIL %s.stall observed=%b expected=%b",
             e.tag, stall, e.s);
    end
    total++;
    assert (zeroFlag === e.z) else begin
      bad++;
      $error("FAIL %s.zf observed=%b expected=%b",
             e.tag, zeroFlag, e.z);
    end
    total++;
    assert (negFlag === e.n) else begin
      bad++;
      $error("FAIL %s.nf observed=%b expected=%b",
             e.tag, negFlag, e.n);
    end
  endtask

  task automatic step(input string tag, input int p,
                      input bit h, input bit s,
                      input bit z, input bit n);
    push(tag, p, h, s, z, n);
    @(posedge clock);
    #1;
    check_one();
  endtask

  task automatic idle();
    jump        = 1'b0;
    bzero       = 1'b0;
    bnegative   = 1'b0;
    mainAddress = 10'd0;
    HLT         = 1'b0;
    enable      = 1'b0;
    aluZero     = 1'b0;
    aluNegative = 1'b0;
    inRequest   = 1'b0;
  endtask

  initial begin
    idle();
    resetn    = 1'b0;
    inConfirm = 1'b1;
    #12;
    push("reset", 0, 0, 0, 0, 0);
    check_one();
    resetn = 1'b1;

    step("inc1", 1, 0, 0, 0, 0);
    step("inc2", 2, 0, 0, 0, 0);
    step("inc3", 3, 0, 0, 0, 0);
    step("inc4", 4, 0, 0, 0, 0);

    enable = 1'b1; aluZero = 1'b1;
    step("latchz", 5, 0, 0, 1, 0);
    idle(); bzero = 1'b1; mainAddress = 10'd300;
    step("bz_take", 300, 0, 0, 1, 0);

    idle(); enable = 1'b1; aluZero = 1'b0;
    step("latchz0", 301, 0, 0, 0, 0);
    idle(); bzero = 1'b1; mainAddress = 10'd300;
    step("bz_skip", 302, 0, 0, 0, 0);

    idle(); enable = 1'b1; aluNegative = 1'b1;
    step("latchn", 303, 0, 0, 0, 1);
    idle(); bnegative = 1'b1; mainAddress = 10'd500;
    step("bn_take", 500, 0, 0, 0, 1);

    idle(); enable = 1'b1; aluZero = 1'b1;
    bzero = 1'b1; mainAddress = 10'd300;
    step("hazard", 501, 0, 0, 1, 0);
    idle(); bzero = 1'b1; mainAddress = 10'd300;
    step("hazard_nx", 300, 0, 0, 1, 0);

    idle(); jump = 1'b1; mainAddress = 10'd1023;
    step("jmp1023", 1023, 0, 0, 1, 0);
    idle();
    step("wrap", 0, 0, 0, 1, 0);
    jump = 1'b1; mainAddress = 10'd7;
    step("jmp7", 7, 0, 0, 1, 0);

    idle(); inRequest = 1'b1;
    step("wait_in", 7, 0, 1, 1, 0);
    idle();
    step("wait_lvl", 7, 0, 1, 1, 0);
    inConfirm = 1'b0;
    enable = 1'b1; aluZero = 1'b0; aluNegative = 1'b1;
    step("wait_d1", 7, 0, 1, 1, 0);
    step("wait_d2", 7, 0, 1, 1, 0);
    step("wait_d3", 7, 0, 1, 1, 0);
    idle();
    inConfirm = 1'b1;
    step("conf_k", 7, 0, 1, 1, 0);
    step("conf_k1", 7, 0, 1, 1, 0);
    step("conf_k2", 7, 0, 1, 1, 0);
    step("conf_k3", 8, 0, 0, 1, 0);

    enable = 1'b1; aluZero = 1'b1; aluNegative = 1'b1;
    jump = 1'b1; mainAddress = 10'd42;
    step("jmp42", 42, 0, 0, 1, 1);
    idle(); HLT = 1'b1; jump = 1'b1; mainAddress = 10'd100;
    step("hlt_jmp", 42, 1, 0, 1, 1);
    idle(); enable = 1'b1; jump = 1'b1;
    inRequest = 1'b1; mainAddress = 10'd9;
    step("halt_frz", 42, 1, 0, 1, 1);
    step("halt_frz2", 42, 1, 0, 1, 1);

    #2;
    resetn = 1'b0;
    #1;
    push("async_rst", 0, 0, 0, 0, 0);
    check_one();
    idle();
    #1;
    resetn = 1'b1;
    step("post1", 1, 0, 0, 0, 0);
    step("post2", 2, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    bad++;
    $display("FAIL timeout observed=running expected=done");
    $fatal(1, "timeout");
  end

endmodule
